ceespu_writeback: RTL
=====================

# ceespu_writeback

Writeback and hazard-tracking unit for the ceespu core, acting as the single writer into the 32×32 register file. It merges results from the ALU pipe and the load/store unit onto the register file's one write port through a 2-entry ALU skid buffer. It also keeps a per-register pending scoreboard that the decode stage uses to stall operand reads until outstanding results have landed.

## Interface
- No parameters. Depth 2, 32 registers and 32-bit data are fixed.
- I_clk  in  1  clock; all state updates on the rising edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_issue_valid  in  1  decode issues an instruction that writes a register.
- I_issue_rd  in  5  destination of the issued instruction.
- I_selA, I_selB  in  5  source registers being read by decode.
- O_busyA, O_busyB  out  1  pending-write flag for I_selA / I_selB (combinational from scoreboard).
- I_alu_valid  in  1  ALU result valid.
- I_alu_rd  in  5  ALU destination.
- I_alu_data  in  32  ALU result.
- O_alu_ready  out  1  skid buffer can accept an ALU result.
- I_ld_valid  in  1  load response valid; always accepted, no backpressure.
- I_ld_rd  in  5  load destination.
- I_ld_data  in  32  load data, already sized and extended by the LSU.
- O_we  out  1  register file write enable (registered).
- O_selD  out  5  register file write address (registered).
- O_dataD  out  32  register file write data (registered).

## Operation
- **Selection (combinational, per cycle), priority high to low:**
  1. I_ld_valid.
  2. Skid buffer head, if the buffer is non-empty.
  3. I_alu_valid with an empty buffer (bypass).
  4. Otherwise no write.
- The selected result is registered into O_we/O_selD/O_dataD at the next edge. If nothing is selected, O_we=0 and O_selD/O_dataD hold their values.
- **ALU acceptance:** an ALU result is accepted when I_alu_valid && O_alu_ready. It is pushed into the buffer unless it is taken by the bypass in the same cycle.
- **Ready:** O_alu_ready = (buffer count < 2), computed from registered count only.
- **Pop/push:** the buffer head is popped when it is selected. Push and pop may occur in the same cycle; count is then unchanged. Order is FIFO.
- **Register 0:** a selected result with rd=0 is consumed normally but produces O_we=0. r0 is never written and never marked busy.
- **Scoreboard:** 32 bits, one per register.
  - Set on I_issue_valid for I_issue_rd≠0.
  - Cleared on the edge at which O_we=1 for O_selD (the same edge the register file samples the write).
  - If set and clear target the same register on the same edge, set wins.
- **Busy outputs:** O_busyA = sb[I_selA], O_busyB = sb[I_selB]; both are 0 for register 0.
- **Illegal input:** issuing to a register that is already busy is illegal, because decode stalls on a busy rd (WAW). The simulation checker flags it. Consequently at most one result per register is ever outstanding, and reordering between loads and buffered ALU results is harmless.
- **ALU overflow:** I_alu_valid while O_alu_ready=0 is not accepted. The ALU pipe must hold its result.

## Timing
- **Reset (asynchronous assert, synchronous release):** O_we=0, O_selD=0, O_dataD=0, scoreboard all 0, buffer empty, O_alu_ready=1, O_busyA=O_busyB=0.
- **Reset mid-operation:** buffered results and pending bits are discarded and no write is issued.
- **Latency:** result input valid at edge N gives O_we=1 in cycle N+1. The register file is updated and the busy bit cleared at edge N+1.
- Worst-case latency for a buffered ALU result equals the number of consecutive load cycles plus 1 for each entry ahead of it.
- **Full:** with count=2, O_alu_ready=0 for that whole cycle, even if a pop occurs. It returns to 1 in the cycle after the pop.
- **Simultaneous load and ALU with an empty buffer:** the load writes and the ALU result enters the buffer (count=1). The ALU result writes in the following cycle if no load arrives.
- **Throughput:** one write per cycle maximum. Sustained loads starve the buffer by design.

## Test plan
1. **Reset:** assert I_rst_n=0 mid-stream with 2 buffered entries → outputs and scoreboard are 0 immediately; O_alu_ready=1 after release; no spurious O_we.
2. **Bypass:** issue r5, then ALU r5=0x1234 alone → O_we=1, O_selD=5, O_dataD=0x1234 one cycle later; O_busyA (selA=5) is 1 until that edge, then 0.
3. **Collision:** load r3=0xAAAA and ALU r4=0xBBBB in the same cycle → r3 written in cycle N+1, r4 in cycle N+2.
4. **Full/backpressure:** 3 consecutive load+ALU cycles → O_alu_ready drops to 0 after two ALU pushes; the third ALU result is held; after loads stop, the results drain in FIFO order with no loss or duplication.
5. **Register 0:** ALU rd=0 data=0xFFFF → no O_we; scoreboard unchanged; O_busyA for selA=0 is always 0.
6. **Set/clear race:** O_we writes r7 on the same edge that a new r7 issue arrives → sb[7] ends at 1.

Source files
------------

// File: rtl/ceespu_writeback_if.sv
// Bundle of the decode, ALU, load and register-file write signals around the
// ceespu writeback unit. The master side drives results; the slave side is the writeback.
interface ceespu_writeback_if;
  logic        I_issue_valid;
  logic [4:0]  I_issue_rd;
  logic [4:0]  I_selA;
  logic [4:0]  I_selB;
  logic        O_busyA;
  logic        O_busyB;
  logic        I_alu_valid;
  logic [4:0]  I_alu_rd;
  logic [31:0] I_alu_data;
  logic        O_alu_ready;
  logic        I_ld_valid;
  logic [4:0]  I_ld_rd;
  logic [31:0] I_ld_data;
  logic        O_we;
  logic [4:0]  O_selD;
  logic [31:0] O_dataD;

  modport master (
    output I_issue_valid, I_issue_rd, I_selA, I_selB,
    output I_alu_valid, I_alu_rd, I_alu_data,
    output I_ld_valid, I_ld_rd, I_ld_data,
    input  O_busyA, O_busyB, O_alu_ready, O_we, O_selD, O_dataD
  );

  modport slave (
    input  I_issue_valid, I_issue_rd, I_selA, I_selB,
    input  I_alu_valid, I_alu_rd, I_alu_data,
    input  I_ld_valid, I_ld_rd, I_ld_data,
    output O_busyA, O_busyB, O_alu_ready, O_we, O_selD, O_dataD
  );
endinterface

// File: rtl/ceespu_writeback.sv
// Single register-file writer: merges loads and ALU results (via a 2-entry skid
// buffer) onto one write port and tracks pending destinations for decode stalls.
module ceespu_writeback (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  ceespu_writeback_if.slave      wb
);

  logic [31:0] buf_data_q [2];
  logic [4:0]  buf_rd_q   [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] sb_q, sb_d;
  logic        we_q, we_d;
  logic [4:0]  selD_q, selD_d;
  logic [31:0] dataD_q, dataD_d;

  logic        sel_valid;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        pop, push, bypass, accept, tail;

  // Loads never stall, so they always win; buffered ALU results beat a new one.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = 32'd0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (wb.I_ld_valid) begin
      sel_valid = 1'b1;
      sel_rd    = wb.I_ld_rd;
      sel_data  = wb.I_ld_data;
    end else if (count_q != 2'd0) begin
      sel_valid = 1'b1;
      sel_rd    = buf_rd_q[head_q];
      sel_data  = buf_data_q[head_q];
      pop       = 1'b1;
    end else if (wb.I_alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = wb.I_alu_rd;
      sel_data  = wb.I_alu_data;
      bypass    = 1'b1;
    end
  end

  assign wb.O_alu_ready = (count_q != 2'd2);
  assign accept         = wb.I_alu_valid && wb.O_alu_ready;
  assign push           = accept && !bypass;
  assign tail           = head_q ^ count_q[0];

  always_comb begin
    head_d  = pop ? ~head_q : head_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    we_d    = sel_valid && (sel_rd != 5'd0);
    selD_d  = sel_valid ? sel_rd   : selD_q;
    dataD_d = sel_valid ? sel_data : dataD_q;
    sb_d    = sb_q;
    if (we_q)
      sb_d[selD_q] = 1'b0;
    // A new issue on the same edge as the retiring write must leave the bit set.
    if (wb.I_issue_valid)
      sb_d[wb.I_issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
      sb_q    <= 32'd0;
      we_q    <= 1'b0;
      selD_q  <= 5'd0;
      dataD_q <= 32'd0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      sb_q    <= sb_d;
      we_q    <= we_d;
      selD_q  <= selD_d;
      dataD_q <= dataD_d;
    end
  end

  always_ff @(posedge I_clk) begin
    if (push) begin
      buf_data_q[tail] <= wb.I_alu_data;
      buf_rd_q[tail]   <= wb.I_alu_rd;
    end
  end

  assign wb.O_busyA = sb_q[wb.I_selA];
  assign wb.O_busyB = sb_q[wb.I_selB];
  assign wb.O_we    = we_q;
  assign wb.O_selD  = selD_q;
  assign wb.O_dataD = dataD_q;

  // Decode stalls on a busy destination, so issuing to one is a decode bug.
  a_no_waw_issue: assert property (@(posedge I_clk) disable iff (!I_rst_n)
    !(wb.I_issue_valid && (wb.I_issue_rd != 5'd0) && sb_q[wb.I_issue_rd] &&
      !(we_q && (selD_q == wb.I_issue_rd))));

endmodule
